// File: rtl/shifter_pkg.sv
// shifter_pkg: operation encoding shared by the pipelined shifter and its stages.
package shifter_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      SLL = 3'd0,
      SRL = 3'd1,
      SRA = 3'd2,
      ROL = 3'd3,
      ROR = 3'd4
   } shift_op_e;
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return op <= ROR;
   endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one registered mux layer shifting by 2**STAGE when its amount bit is set.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int SHW = 5,
   parameter int STAGE = 0
) (
   input logic clk,
   input logic rst_n,
   input logic load,
   input logic up_valid,
   input logic [WIDTH-1:0] up_data,
   input logic [SHW-1:0] up_amt,
   input logic [OP_W-1:0] up_op,
   input logic up_sign,
   input logic [TAG_W-1:0] up_tag,
   input logic up_illegal,
   output logic valid,
   output logic [WIDTH-1:0] data,
   output logic [SHW-1:0] amt,
   output logic [OP_W-1:0] op,
   output logic sign,
   output logic [TAG_W-1:0] tag,
   output logic illegal
);
   localparam int S = 1 << STAGE;
   logic [WIDTH-1:0] shl, shr, fill, res;
   assign shl = up_data << S;
   assign shr = up_data >> S;
   // sign bit travels from the original operand, so arithmetic fill stays correct in every stage
   assign fill = up_sign ? ~({WIDTH{1'b1}} >> S) : '0;
   always_comb
      res = !up_amt[STAGE] ? up_data :
            up_op == SLL ? shl :
            up_op == SRL ? shr :
            up_op == SRA ? (shr | fill) :
            up_op == ROL ? (shl | (up_data >> (WIDTH - S))) :
            up_op == ROR ? (shr | (up_data << (WIDTH - S))) : up_data;
   always_ff @(posedge clk)
      if (!rst_n) begin
         valid <= 1'b0;
         data <= '0;
         amt <= '0;
         op <= '0;
         sign <= 1'b0;
         tag <= '0;
         illegal <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
         if (up_valid) begin
            data <= res;
            amt <= up_amt;
            op <= up_op;
            sign <= up_sign;
            tag <= up_tag;
            illegal <= up_illegal;
         end
      end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: valid/ready pipelined barrel shifter, one stage per shift-amount bit.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SHW = $clog2(WIDTH)
) (
   input logic clk,
   input logic rst_n,
   input logic in_valid,
   output logic in_ready,
   input logic [WIDTH-1:0] in_data,
   input logic [SHW-1:0] in_amt,
   input logic [OP_W-1:0] in_op,
   input logic [TAG_W-1:0] in_tag,
   output logic out_valid,
   input logic out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic out_illegal
);
   logic [SHW:0] vld, ill;
   logic [SHW-1:0] rdy;
   logic [WIDTH-1:0] dat [SHW+1];
   logic [SHW-1:0] amt [SHW+1];
   logic [OP_W-1:0] op [SHW+1];
   logic sgn [SHW+1];
   logic [TAG_W-1:0] tag [SHW+1];
   assign vld[0] = in_valid;
   assign dat[0] = in_data;
   assign amt[0] = in_amt;
   assign op[0] = in_op;
   assign sgn[0] = in_data[WIDTH-1];
   assign tag[0] = in_tag;
   assign ill[0] = !is_legal_op(in_op);
   assign in_ready = rst_n && rdy[0];
   assign out_valid = vld[SHW];
   assign out_data = dat[SHW];
   assign out_tag = tag[SHW];
   assign out_illegal = ill[SHW];
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      // a stage may load unless it and every stage after it is full while the consumer stalls
      assign rdy[k] = out_ready || !(&vld[SHW:k+1]);
      shift_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SHW(SHW), .STAGE(k)) u_stage (
         .clk(clk),
         .rst_n(rst_n),
         .load(rdy[k]),
         .up_valid(vld[k]),
         .up_data(dat[k]),
         .up_amt(amt[k]),
         .up_op(op[k]),
         .up_sign(sgn[k]),
         .up_tag(tag[k]),
         .up_illegal(ill[k]),
         .valid(vld[k+1]),
         .data(dat[k+1]),
         .amt(amt[k+1]),
         .op(op[k+1]),
         .sign(sgn[k+1]),
         .tag(tag[k+1]),
         .illegal(ill[k+1])
      );
   end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard bench with a whole-word reference model and a decoupled output monitor.
module tb_pipelined_shifter;
   import shifter_pkg::*;
   localparam int W = 32;
   localparam int T = 4;
   localparam int SH = 5;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_illegal;
   logic [W-1:0] in_data = '0, out_data;
   logic [SH-1:0] in_amt = '0;
   logic [2:0] in_op = '0;
   logic [T-1:0] in_tag = '0, out_tag;
   int checks = 0, failures = 0, cyc = 0, hs_n = 0, last_wait = 0;
   typedef struct {
      logic [W-1:0] d;
      logic [T-1:0] t;
      logic i;
   } exp_t;
   exp_t q[$];
   exp_t e_mon;
   logic stall_prev = 1'b0;
   logic [W-1:0] d_prev = '0;
   logic [T-1:0] t_prev = '0;

   pipelined_shifter #(.WIDTH(W), .TAG_W(T)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // whole-word reference: rotates via a doubled operand, SRA via signed arithmetic shift
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SH-1:0] a, input logic [2:0] op);
      logic [2*W-1:0] dd;
      case (op)
         3'd0: return d << a;
         3'd1: return d >> a;
         3'd2: return W'($signed(d) >>> a);
         3'd3: begin dd = {d, d} << a; return dd[2*W-1:W]; end
         3'd4: begin dd = {d, d} >> a; return dd[W-1:0]; end
         default: return d;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, d_prev);
            check("hold_tag", out_tag, t_prev);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out got tag=%0h data=%0h want=none", out_tag, out_data);
            end else begin
               e_mon = q.pop_front();
               check("out_data", out_data, e_mon.d);
               check("out_tag", out_tag, e_mon.t);
               check("out_illegal", out_illegal, e_mon.i);
            end
         end
         stall_prev = out_valid && !out_ready;
         d_prev = out_data;
         t_prev = out_tag;
      end else stall_prev = 1'b0;
   end

   task automatic issue(input logic [W-1:0] d, input logic [SH-1:0] a, input logic [2:0] op,
                        input logic [T-1:0] tg, input logic [W-1:0] ed, input logic ei);
      exp_t e;
      in_valid = 1'b1;
      in_data = d;
      in_amt = a;
      in_op = op;
      in_tag = tg;
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            e.d = ed;
            e.t = tg;
            e.i = ei;
            q.push_back(e);
            hs_n++;
            last_wait = w;
            #1 in_valid = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL issue_timeout tag=%0h got in_ready=0 want 1", tg);
      in_valid = 1'b0;
   endtask

   task automatic issue_m(input logic [W-1:0] d, input logic [SH-1:0] a, input logic [2:0] op, input logic [T-1:0] tg);
      issue(d, a, op, tg, model(d, a, op), op > 3'd4);
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && q.size() != 0; n++) @(negedge clk);
      check("drain_left", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic latency(input int h);
      int lat = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = cyc - h;
            break;
         end
      end
      check("latency", lat, SH);
   endtask

   initial begin
      int h, ok, base, waits;
      bit done;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_illegal", out_illegal, 0);
      check("rst_release_ready", in_ready, 1);
      @(posedge clk);
      #1;
      // sweep: every op and amount on a fixed operand, streamed back to back
      h = -1;
      fork
         for (int op = 0; op < 5; op++)
            for (int a = 0; a < 32; a++) issue_m(32'hA5A5A5A5, SH'(a), 3'(op), T'(a));
         begin
            for (int n = 0; n < 20; n++) begin
               @(negedge clk);
               if (in_valid && in_ready) begin
                  h = cyc;
                  break;
               end
            end
            latency(h);
            ok = 1;
            for (int n = 1; n < 160; n++) begin
               @(negedge clk);
               if (!out_valid) ok = 0;
            end
            check("throughput", ok, 1);
         end
      join
      drain();
      issue(32'hA5A5A5A5, 4, 3'd0, 1, 32'h5A5A5A50, 0);
      issue(32'hA5A5A5A5, 8, 3'd1, 2, 32'h00A5A5A5, 0);
      issue(32'hA5A5A5A5, 8, 3'd2, 3, 32'hFFA5A5A5, 0);
      issue(32'h80000000, 31, 3'd2, 4, 32'hFFFFFFFF, 0);
      issue(32'h00000001, 1, 3'd4, 5, 32'h80000000, 0);
      issue(32'h80000001, 4, 3'd3, 6, 32'h00000018, 0);
      drain();
      // backpressure: consumer stalls 7 cycles while 10 ops are offered
      base = hs_n;
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 10; i++) issue_m($urandom, SH'($urandom), 3'($urandom_range(0, 4)), T'(i));
         begin
            repeat (7) @(negedge clk);
            check("bp_accepted", hs_n - base, 5);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      // bubble collapse: a lone op leaves empty stages ahead of four stalled ops
      issue_m(32'h13579BDF, 3, 3'd3, 7);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      waits = 0;
      for (int i = 0; i < 4; i++) begin
         issue_m($urandom, SH'($urandom), 3'($urandom_range(0, 4)), T'(8 + i));
         waits += last_wait;
      end
      check("bubble_waits", waits, 0);
      @(negedge clk);
      check("bubble_full_ready", in_ready, 0);
      check("bubble_out_valid", out_valid, 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
      issue(32'h12345678, 7, 3'b110, 12, 32'h12345678, 1);
      issue_m(32'h12345678, 7, 3'd1, 13);
      drain();
      // randomized ops, including illegal encodings, under random backpressure
      done = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) issue_m($urandom, SH'($urandom), 3'($urandom_range(0, 7)), T'($urandom));
            done = 1;
         end
         while (!done) begin
            @(posedge clk);
            #1 out_ready = $urandom_range(0, 3) != 0;
         end
      join
      out_ready = 1'b1;
      drain();
      // reset with three ops in flight: none of them may ever be emitted
      issue_m(32'hDEADBEEF, 1, 3'd0, 4'hA);
      issue_m(32'hCAFEF00D, 2, 3'd1, 4'hB);
      issue_m(32'h0BADF00D, 3, 3'd3, 4'hC);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      @(negedge clk);
      check("postrst_out_valid", out_valid, 0);
      check("postrst_out_data", out_data, 0);
      check("postrst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      issue_m(32'h00F0F00F, 5, 3'd4, 4'hD);
      h = cyc - 1;
      latency(h);
      drain();
      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
